// File: rtl/gray_seq_decoder.sv
// Gray-code stream monitor: converts each accepted sample to binary, checks +1 steps, tracks lock and errors.
// Optional macro GRAY_BIDIR_EN additionally accepts -1 steps (down-counting source).
module gray_seq_decoder #(
   parameter int WIDTH    = 4,
   parameter int LOCK_CNT = 3,
   parameter int ERR_W    = 8
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_gray_valid,
   input  logic [WIDTH-1:0] i_gray,
   output logic [WIDTH-1:0] o_bin,
   output logic             o_bin_valid,
   output logic             o_lock,
   output logic             o_step_err,
   output logic [ERR_W-1:0] o_err_cnt
);

   localparam int GW = (LOCK_CNT < 1) ? 1 : $clog2(LOCK_CNT + 1);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ACQUIRE = 2'd1,
      S_LOCKED  = 2'd2
   } state_t;

   state_t           r_state, w_state_n;
   logic [WIDTH-1:0] r_bin, w_bin_n;
   logic [GW-1:0]    r_good_cnt, w_good_cnt_n;
   logic             r_bin_valid, w_bin_valid_n;
   logic             r_step_err, w_step_err_n;
   logic [ERR_W-1:0] r_err_cnt, w_err_cnt_n;

   logic [WIDTH-1:0] w_bin;
   logic [WIDTH-1:0] w_inc;
   logic [WIDTH-1:0] w_dec;
   logic             w_legal;

   always_comb begin
      w_bin = '0;
      w_bin[WIDTH-1] = i_gray[WIDTH-1];
      for (int i = WIDTH - 2; i >= 0; i--)
         w_bin[i] = w_bin[i+1] ^ i_gray[i];
   end

   // r_bin doubles as prev_bin: both take every accepted sample.
   assign w_inc = r_bin + WIDTH'(1);
   assign w_dec = r_bin - WIDTH'(1);

`ifdef GRAY_BIDIR_EN
   assign w_legal = (w_bin == w_inc) || (w_bin == w_dec);
`else
   assign w_legal = (w_bin == w_inc);
`endif

   always_comb begin
      w_state_n     = r_state;
      w_bin_n       = r_bin;
      w_good_cnt_n  = r_good_cnt;
      w_bin_valid_n = 1'b0;
      w_step_err_n  = 1'b0;
      w_err_cnt_n   = r_err_cnt;
      if (i_gray_valid) begin
         w_bin_n       = w_bin;
         w_bin_valid_n = 1'b1;
         case (r_state)
            S_IDLE: begin
               w_good_cnt_n = '0;
               w_state_n    = S_ACQUIRE;
            end
            S_ACQUIRE: begin
               if (!w_legal) begin
                  w_good_cnt_n = '0;
               end else if (r_good_cnt >= GW'(LOCK_CNT - 1)) begin
                  w_good_cnt_n = GW'(LOCK_CNT);
                  w_state_n    = S_LOCKED;
               end else begin
                  w_good_cnt_n = r_good_cnt + GW'(1);
               end
            end
            S_LOCKED: begin
               if (!w_legal) begin
                  w_step_err_n = 1'b1;
                  w_good_cnt_n = '0;
                  w_state_n    = S_ACQUIRE;
                  if (r_err_cnt != {ERR_W{1'b1}})
                     w_err_cnt_n = r_err_cnt + ERR_W'(1);
               end
            end
            default: begin
               w_good_cnt_n = '0;
               w_state_n    = S_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state     <= S_IDLE;
         r_bin       <= '0;
         r_good_cnt  <= '0;
         r_bin_valid <= 1'b0;
         r_step_err  <= 1'b0;
         r_err_cnt   <= '0;
      end else begin
         r_state     <= w_state_n;
         r_bin       <= w_bin_n;
         r_good_cnt  <= w_good_cnt_n;
         r_bin_valid <= w_bin_valid_n;
         r_step_err  <= w_step_err_n;
         r_err_cnt   <= w_err_cnt_n;
      end
   end

   assign o_bin       = r_bin;
   assign o_bin_valid = r_bin_valid;
   assign o_lock      = (r_state == S_LOCKED);
   assign o_step_err  = r_step_err;
   assign o_err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_gray_seq_decoder.sv
// Directed bench for gray_seq_decoder: vector table plus a saturation sequence.
module tb_gray_seq_decoder;

`ifdef GRAY_BIDIR_EN
   localparam bit BIDIR = 1'b1;
`else
   localparam bit BIDIR = 1'b0;
`endif

   logic       i_clk = 1'b0;
   logic       i_rst = 1'b1;
   logic       i_gray_valid = 1'b0;
   logic [3:0] i_gray = '0;
   logic [3:0] o_bin;
   logic       o_bin_valid;
   logic       o_lock;
   logic       o_step_err;
   logic [7:0] o_err_cnt;

   int total = 0;
   int fails = 0;

   gray_seq_decoder #(.WIDTH(4), .LOCK_CNT(3), .ERR_W(8)) dut (
      .i_clk        (i_clk),
      .i_rst        (i_rst),
      .i_gray_valid (i_gray_valid),
      .i_gray       (i_gray),
      .o_bin        (o_bin),
      .o_bin_valid  (o_bin_valid),
      .o_lock       (o_lock),
      .o_step_err   (o_step_err),
      .o_err_cnt    (o_err_cnt)
   );

   always #5 i_clk = ~i_clk;

   typedef struct {
      logic       rst;
      logic       vld;
      logic [3:0] b;
      logic [3:0] eb;
      logic       ebv;
      logic       el;
      logic       ese;
      logic [7:0] ec;
   } vec_t;

   vec_t tbl[$];

   function automatic logic [3:0] b2g(input logic [3:0] b);
      return b ^ (b >> 1);
   endfunction

   function automatic void add(input logic rst, input logic vld, input logic [3:0] b,
                               input logic [3:0] eb, input logic ebv, input logic el,
                               input logic ese, input logic [7:0] ec);
      vec_t v;
      v.rst = rst; v.vld = vld; v.b = b; v.eb = eb;
      v.ebv = ebv; v.el = el; v.ese = ese; v.ec = ec;
      tbl.push_back(v);
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   // Inputs change on the falling edge; outputs are read 1 time unit after the rising edge.
   task automatic cyc(input logic rst, input logic vld, input logic [3:0] b);
      @(negedge i_clk);
      i_rst        = rst;
      i_gray_valid = vld;
      i_gray       = b2g(b);
      @(posedge i_clk);
      #1;
   endtask

   initial begin
      logic [3:0] prev;
      logic [7:0] exp_cnt;

      // reset
      add(1, 0, 0, 0, 0, 0, 0, 0);
      // full up-count 0..15, lock after the 4th sample
      for (int i = 0; i < 16; i++)
         add(0, 1, 4'(i), 4'(i), 1, (i >= 3), 0, 0);
      // wrap 15 -> 0 -> 1
      add(0, 1, 0, 0, 1, 1, 0, 0);
      add(0, 1, 1, 1, 1, 1, 0, 0);
      for (int i = 2; i <= 5; i++)
         add(0, 1, 4'(i), 4'(i), 1, 1, 0, 0);
      // 5 -> 7 jump while locked
      add(0, 1, 7, 7, 1, 0, 1, 1);
      add(0, 1, 8, 8, 1, 0, 0, 1);
      add(0, 1, 9, 9, 1, 0, 0, 1);
      add(0, 1, 10, 10, 1, 1, 0, 1);
      add(0, 0, 0, 10, 0, 1, 0, 1);
      // valid gap: o_bin holds, lock unaffected
      add(0, 1, 11, 11, 1, 1, 0, 1);
      for (int i = 0; i < 5; i++)
         add(0, 0, 3, 11, 0, 1, 0, 1);
      add(0, 1, 12, 12, 1, 1, 0, 1);
      // repeated sample is illegal
      add(0, 1, 12, 12, 1, 0, 1, 2);
      add(0, 1, 13, 13, 1, 0, 0, 2);
      add(0, 1, 14, 14, 1, 0, 0, 2);
      add(0, 1, 15, 15, 1, 1, 0, 2);
      // reset mid-stream dominates a valid sample
      add(1, 1, 0, 0, 0, 0, 0, 0);
      add(0, 1, 6, 6, 1, 0, 0, 0);
      add(0, 1, 7, 7, 1, 0, 0, 0);
      add(0, 1, 8, 8, 1, 0, 0, 0);
      add(0, 1, 9, 9, 1, 1, 0, 0);
      // -1 step while locked
      add(0, 1, 8, 8, 1, BIDIR, !BIDIR, BIDIR ? 8'd0 : 8'd1);
      // down-count 3,2,1,0,15 from fresh start
      add(1, 0, 0, 0, 0, 0, 0, 0);
      add(0, 1, 3, 3, 1, 0, 0, 0);
      add(0, 1, 2, 2, 1, 0, 0, 0);
      add(0, 1, 1, 1, 1, 0, 0, 0);
      add(0, 1, 0, 0, 1, BIDIR, 0, 0);
      add(0, 1, 15, 15, 1, BIDIR, 0, 0);

      for (int n = 0; n < tbl.size(); n++) begin
         cyc(tbl[n].rst, tbl[n].vld, tbl[n].b);
         chk($sformatf("v%0d.bin", n),      32'(o_bin),       32'(tbl[n].eb));
         chk($sformatf("v%0d.bin_vld", n),  32'(o_bin_valid), 32'(tbl[n].ebv));
         chk($sformatf("v%0d.lock", n),     32'(o_lock),      32'(tbl[n].el));
         chk($sformatf("v%0d.step_err", n), 32'(o_step_err),  32'(tbl[n].ese));
         chk($sformatf("v%0d.err_cnt", n),  32'(o_err_cnt),   32'(tbl[n].ec));
      end

      // saturation: 300 error bursts, relocking between each
      cyc(1, 0, 0);
      chk("sat.reset_cnt", 32'(o_err_cnt), 32'd0);
      for (int i = 0; i < 4; i++)
         cyc(0, 1, 4'(i));
      chk("sat.locked", 32'(o_lock), 32'd1);
      prev = 4'd3;
      for (int k = 1; k <= 300; k++) begin
         prev = prev + 4'd2;
         cyc(0, 1, prev);
         exp_cnt = (k > 255) ? 8'd255 : 8'(k);
         chk($sformatf("sat%0d.err", k), 32'(o_step_err), 32'd1);
         chk($sformatf("sat%0d.cnt", k), 32'(o_err_cnt), 32'(exp_cnt));
         for (int j = 0; j < 3; j++) begin
            prev = prev + 4'd1;
            cyc(0, 1, prev);
         end
         chk($sformatf("sat%0d.relock", k), 32'(o_lock), 32'd1);
      end
      cyc(0, 0, 0);
      chk("sat.final_cnt", 32'(o_err_cnt), 32'd255);
      chk("sat.final_err", 32'(o_step_err), 32'd0);
      cyc(1, 0, 0);
      chk("sat.cleared", 32'(o_err_cnt), 32'd0);

      $display("%0d/%0d checks passed", total - fails, total);
      $finish;
   end

endmodule
